// File: rtl/keypad3c4r_emu.sv
// Keypad matrix emulator: queued key codes are driven onto the column
// lines of a 3x4 keypad so a row-scanning reader sees real presses.
module keypad3c4r_emu #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     code_valid,
  input  logic [3:0]               code,
  output logic                     code_ready,
  input  logic [3:0]               keypadr,
  output logic [2:0]               keypadc,
  output logic                     pressing,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cur_q;
  logic             pressing_q;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] count_q;

  logic       push;
  logic       pop;
  logic       nonempty;
  logic       hold_done;
  logic       gap_done;
  logic [3:0] head;
  logic [3:0] row_oh;
  logic [2:0] col_oh;

  assign nonempty   = (count_q != '0);
  assign code_ready = (count_q != CW'(DEPTH));
  assign push       = code_valid & code_ready;
  assign hold_done  = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  assign gap_done   = (cnt_q == CNT_W'(GAP_CYCLES - 1));
  assign head       = mem_q[rd_q];
  assign pop        = nonempty &
                      ((state_q == IDLE) |
                       ((state_q == GAP) & gap_done));

  assign fifo_count = count_q;
  assign pressing   = pressing_q;
  assign busy       = nonempty | (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Counter is cleared on every state change so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_q      <= 4'hf;
      pressing_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            cur_q      <= head;
            cnt_q      <= '0;
            pressing_q <= (head <= 4'hb);
            state_q    <= PRESS;
          end
        end
        PRESS: begin
          if (hold_done) begin
            cnt_q      <= '0;
            pressing_q <= 1'b0;
            state_q    <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_done) begin
            cnt_q <= '0;
            if (pop) begin
              cur_q      <= head;
              pressing_q <= (head <= 4'hb);
              state_q    <= PRESS;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q      <= '0;
          pressing_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    row_oh = 4'b0000;
    col_oh = 3'b000;
    unique case (cur_q)
      4'h1: begin row_oh = 4'b0001; col_oh = 3'b001; end
      4'h2: begin row_oh = 4'b0001; col_oh = 3'b010; end
      4'h3: begin row_oh = 4'b0001; col_oh = 3'b100; end
      4'h4: begin row_oh = 4'b0010; col_oh = 3'b001; end
      4'h5: begin row_oh = 4'b0010; col_oh = 3'b010; end
      4'h6: begin row_oh = 4'b0010; col_oh = 3'b100; end
      4'h7: begin row_oh = 4'b0100; col_oh = 3'b001; end
      4'h8: begin row_oh = 4'b0100; col_oh = 3'b010; end
      4'h9: begin row_oh = 4'b0100; col_oh = 3'b100; end
      4'ha: begin row_oh = 4'b1000; col_oh = 3'b001; end
      4'h0: begin row_oh = 4'b1000; col_oh = 3'b010; end
      4'hb: begin row_oh = 4'b1000; col_oh = 3'b100; end
      default: ;
    endcase
  end

  // Unregistered so the scanner sees the column in the cycle it drives the row
  always_comb begin
    keypadc = 3'b000;
    if ((state_q == PRESS) && |(row_oh & keypadr)) begin
      keypadc = col_oh;
    end
  end

endmodule
